// File: rtl/mem_responder.sv
// mem_responder: memory-side responder with fixed-latency read pipeline and credit-limited reads.
// Ports: clk, rst (async, active-high); m_req_vld/m_req_rdy/m_req_we/m_req_addr/m_req_wdata request
// handshake; m_rsp_vld/m_rsp_data response pulse (no backpressure); m_rsp_ack returns one credit;
// init_busy high while memory is being cleared. Optional macro MEM_RSP_STALL_EN adds LFSR stalls.
package constants_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

module mem_responder
  import constants_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DEPTH           = 256,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_req_vld,
  output logic                  m_req_rdy,
  input  logic                  m_req_we,
  input  logic [ADDR_WIDTH-1:0] m_req_addr,
  input  logic [DATA_WIDTH-1:0] m_req_wdata,
  output logic                  m_rsp_vld,
  output logic [DATA_WIDTH-1:0] m_rsp_data,
  input  logic                  m_rsp_ack,
  output logic                  init_busy
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {INIT, RUN} state_e;
  state_e                state_q, state_d;
  logic [IW-1:0]         clr_ptr_q, clr_ptr_d;
  logic [3:0]            count_q, count_d;
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];
  logic [DATA_WIDTH-1:0] data_d [LATENCY];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         idx, mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  accept, rd_acc, ack_ok, mem_we, stall;

`ifdef MEM_RSP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = state_q == RUN ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  assign stall  = lfsr_q[0];
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= INIT;
    else     state_q <= state_d;

  always_comb
    state_d = (state_q == INIT && clr_ptr_q == IW'(DEPTH - 1)) ? RUN : state_q;

  always_comb begin
    init_busy = state_q == INIT;
    m_req_rdy = state_q == RUN && count_q < 4'(MAX_OUTSTANDING) && !stall;
  end

  always_comb begin
    idx       = m_req_addr[IW-1:0];
    accept    = m_req_vld & m_req_rdy;
    rd_acc    = accept & ~m_req_we;
    // Acks are meaningless during INIT and must never underflow the credit count.
    ack_ok    = m_rsp_ack && state_q == RUN && count_q != 4'd0;
    count_d   = count_q + 4'(rd_acc) - 4'(ack_ok);
    clr_ptr_d = init_busy ? clr_ptr_q + 1'b1 : clr_ptr_q;
    // The clear sequence and request writes share one write port; INIT never accepts requests.
    mem_we    = init_busy | (accept & m_req_we);
    mem_waddr = init_busy ? clr_ptr_q : idx;
    mem_wdata = init_busy ? '0 : m_req_wdata;
    vld_d     = LATENCY'({vld_q, rd_acc});
  end

  // Data stages only move with a valid token so the output holds its last response.
  for (genvar i = 0; i < LATENCY; i++) begin : g_pipe
    if (i == 0) begin : g_head
      assign data_d[i] = rd_acc ? mem[idx] : data_q[i];
    end else begin : g_tail
      assign data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clr_ptr_q <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      data_q    <= '{default: '0};
    end else begin
      clr_ptr_q <= clr_ptr_d;
      count_q   <= count_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
    end

  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;

  assign m_rsp_vld  = vld_q[LATENCY-1];
  assign m_rsp_data = data_q[LATENCY-1];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a queue-based model.
module tb_mem_responder;
  localparam int L = 2;
  localparam int MAX = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_req_vld = 1'b0, m_req_we = 1'b0, m_rsp_ack = 1'b0;
  logic [7:0]  m_req_addr = '0;
  logic [31:0] m_req_wdata = '0;
  logic        m_req_rdy, m_rsp_vld, init_busy;
  logic [31:0] m_rsp_data;

  mem_responder dut (
    .clk(clk), .rst(rst), .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_rsp_vld(m_rsp_vld),
    .m_rsp_data(m_rsp_data), .m_rsp_ack(m_rsp_ack), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [31:0] data;} rsp_t;
  rsp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  int          checks = 0, errors = 0;
  int          cnum = 0, cnt = 0, delivered = 0, init_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cnt = 0;
    delivered = 0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // One clock cycle: drive, check at negedge, update the model as of the coming edge.
  task automatic cyc(input bit v, input bit we, input logic [7:0] a, input logic [31:0] d, input bit ack);
    bit exp_v, busy, acc;
    m_req_vld = v; m_req_we = we; m_req_addr = a; m_req_wdata = d; m_rsp_ack = ack;
    @(negedge clk);
    busy  = init_left > 0;
    exp_v = q.size() > 0 && q[0].due == cnum;
    chk("rsp_vld", 32'(m_rsp_vld), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_data", m_rsp_data, q[0].data);
      void'(q.pop_front());
      delivered++;
    end
    chk("init_busy", 32'(init_busy), 32'(busy));
`ifdef MEM_RSP_STALL_EN
    chk("rdy_limit", 32'(m_req_rdy & (busy | cnt >= MAX)), 32'd0);
`else
    chk("req_rdy", 32'(m_req_rdy), 32'(!busy && cnt < MAX));
`endif
    acc = v && m_req_rdy;
    if (acc && we) mem_m[a] = d;
    if (acc && !we) q.push_back('{cnum + L, mem_m[a]});
    if (!busy) begin
      cnt += int'(acc && !we);
      if (ack && cnt > int'(acc && !we)) cnt--;
      else if (ack && cnt > 0 && !(acc && !we)) cnt--;
      if (ack && delivered > 0) delivered--;
    end
    if (init_left > 0) init_left--;
    @(posedge clk);
    #1;
    cnum++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 32'h0, 0);
  endtask

  task automatic drain();
    for (int g = 0; g < 64 && (q.size() > 0 || cnt > 0); g++) cyc(0, 0, 8'h00, 32'h0, cnt > 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_vld", 32'(m_rsp_vld), 32'd0);
    chk("rst_rsp_data", m_rsp_data, 32'd0);
    chk("rst_req_rdy", 32'(m_req_rdy), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(DEPTH + 1);
    cyc(1, 0, 8'h10, 32'h0, 0);
    idle(3);
    drain();
    // Write then read the same word on the next cycle.
    cyc(1, 1, 8'h05, 32'hDEADBEEF, 0);
    cyc(1, 0, 8'h05, 32'h0, 0);
    idle(3);
    drain();
    // Credit exhaustion: two reads, third stalls, one ack releases it.
    cyc(1, 0, 8'h05, 32'h0, 0);
    cyc(1, 0, 8'h06, 32'h0, 0);
    cyc(1, 0, 8'h07, 32'h0, 1);
    cyc(1, 0, 8'h07, 32'h0, 0);
    idle(3);
    drain();
    // Read and ack in the same cycle with one credit used.
    cyc(1, 0, 8'h05, 32'h0, 0);
    cyc(1, 0, 8'h08, 32'h0, 1);
    idle(3);
    drain();
    // Ack with no credits used must not underflow.
    cyc(0, 0, 8'h00, 32'h0, 1);
    cyc(1, 0, 8'h01, 32'h0, 0);
    cyc(1, 0, 8'h02, 32'h0, 0);
    idle(3);
    drain();
    // Reset one cycle after a read accept drops the response.
    cyc(1, 1, 8'h22, 32'h12345678, 0);
    cyc(1, 0, 8'h22, 32'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_vld", 32'(m_rsp_vld), 32'd0);
    chk("mid_rst_init_busy", 32'(init_busy), 32'd1);
    chk("mid_rst_req_rdy", 32'(m_req_rdy), 32'd0);
    @(posedge clk);
    #1;
    cnum++;
    rst = 1'b0;
    model_reset();
    idle(DEPTH + 1);
    cyc(1, 0, 8'h22, 32'h0, 0);
    idle(3);
    drain();
    // Random mix of reads, writes and acks.
    for (int n = 0; n < 1000; n++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 31)),
          $urandom, delivered > 0 && $urandom_range(0, 1) == 1);
    idle(3);
    drain();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
